// File: rtl/multi_host_reg_bank.sv
// multi_host_reg_bank: round-robin arbiter from NUM_HOSTS request channels onto a shared
// config (RW) / status (RO) register bank with registered req/rsp handshake and error reporting.
module multi_host_reg_bank #(
    parameter int NUM_HOSTS = 2,
    parameter int NUM_CFG = 8,
    parameter int NUM_STATUS = 8,
    parameter int REG_WIDTH = 8,
    parameter int ADDR_W = 8,
    parameter logic [NUM_CFG*REG_WIDTH-1:0] CFG_RESET = '0
) (
    input  logic                            clk,
    input  logic                            rstb,
    input  logic                            ena,
    input  logic [NUM_HOSTS-1:0]            req_valid,
    input  logic [NUM_HOSTS-1:0]            req_wr_rdn,
    input  logic [NUM_HOSTS*ADDR_W-1:0]     req_addr,
    input  logic [NUM_HOSTS*REG_WIDTH-1:0]  req_wdata,
    output logic [NUM_HOSTS-1:0]            req_ready,
    output logic [NUM_HOSTS-1:0]            rsp_valid,
    output logic [REG_WIDTH-1:0]            rsp_rdata,
    output logic                            rsp_err,
    output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
    input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
    output logic [NUM_CFG-1:0]              cfg_wr_strobe
);
    localparam int HW = NUM_HOSTS > 1 ? $clog2(NUM_HOSTS) : 1;
    typedef enum logic {IDLE, EXEC} state_t;
    state_t r_state, w_next;
    logic [HW-1:0] r_last_grant, r_idx;
    logic r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [REG_WIDTH-1:0] r_wdata, r_rdata;
    logic [NUM_CFG*REG_WIDTH-1:0] r_cfg;
    logic [NUM_HOSTS-1:0] r_ready, r_rsp_valid;
    logic r_err;
    logic [NUM_CFG-1:0] r_strobe;
    int w_gnt, w_j, w_addr;
    logic w_grant, w_is_cfg, w_is_sts;
    // Scan from farthest to nearest offset so the host closest after last_grant is kept last.
    always_comb begin
        w_gnt = 0;
        w_j = 0;
        for (int k = NUM_HOSTS; k >= 1; k--) begin
            w_j = (int'(r_last_grant) + k) % NUM_HOSTS;
            w_gnt = req_valid[w_j +: 1] ? w_j : w_gnt;
        end
    end
    assign w_grant  = (r_state == IDLE) && ena && (|req_valid);
    assign w_addr   = int'(r_addr);
    assign w_is_cfg = w_addr < NUM_CFG;
    assign w_is_sts = !w_is_cfg && (w_addr < NUM_CFG + NUM_STATUS);
    always_ff @(posedge clk) begin
        if (!rstb) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE) w_next = w_grant ? EXEC : IDLE;
        else                 w_next = IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_last_grant <= HW'(NUM_HOSTS - 1);
            r_idx        <= '0;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cfg        <= CFG_RESET;
            r_ready      <= '0;
            r_rsp_valid  <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_strobe     <= '0;
        end else begin
            r_ready     <= '0;
            r_rsp_valid <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_strobe    <= '0;
            if (w_grant) begin
                r_ready      <= NUM_HOSTS'(1) << w_gnt;
                r_last_grant <= HW'(w_gnt);
                r_idx        <= HW'(w_gnt);
                r_wr         <= req_wr_rdn[w_gnt +: 1];
                r_addr       <= req_addr[w_gnt*ADDR_W +: ADDR_W];
                r_wdata      <= req_wdata[w_gnt*REG_WIDTH +: REG_WIDTH];
            end
            if (r_state == EXEC) begin
                r_rsp_valid <= NUM_HOSTS'(1) << r_idx;
                r_err       <= !(w_is_cfg || (w_is_sts && !r_wr));
                if (w_is_cfg && r_wr) begin
                    r_cfg[w_addr*REG_WIDTH +: REG_WIDTH] <= r_wdata;
                    r_strobe <= NUM_CFG'(1) << w_addr;
                end else if (w_is_cfg) begin
                    r_rdata <= r_cfg[w_addr*REG_WIDTH +: REG_WIDTH];
                end else if (w_is_sts && !r_wr) begin
                    r_rdata <= status_regs[(w_addr - NUM_CFG)*REG_WIDTH +: REG_WIDTH];
                end
            end
        end
    end
    assign req_ready     = r_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rdata;
    assign rsp_err       = r_err;
    assign config_regs   = r_cfg;
    assign cfg_wr_strobe = r_strobe;
endmodule

// File: tb/tb_multi_host_reg_bank.sv
// tb_multi_host_reg_bank: directed stimulus with a response scoreboard for multi_host_reg_bank.
module tb_multi_host_reg_bank;
    localparam int NH = 2, NC = 8, NS = 8, RW = 8, AW = 8;
    localparam logic [NC*RW-1:0] CR = 64'h0000_0000_0000_00A5;
    logic clk = 1'b0, rstb = 1'b0, ena = 1'b0;
    logic [NH-1:0] req_valid = '0, req_wr_rdn = '0;
    logic [NH*AW-1:0] req_addr = '0;
    logic [NH*RW-1:0] req_wdata = '0;
    logic [NH-1:0] req_ready, rsp_valid;
    logic [RW-1:0] rsp_rdata;
    logic rsp_err;
    logic [NC*RW-1:0] config_regs;
    logic [NS*RW-1:0] status_regs = '0;
    logic [NC-1:0] cfg_wr_strobe;

    multi_host_reg_bank #(.NUM_HOSTS(NH), .NUM_CFG(NC), .NUM_STATUS(NS), .REG_WIDTH(RW),
        .ADDR_W(AW), .CFG_RESET(CR)) dut (
        .clk(clk), .rstb(rstb), .ena(ena), .req_valid(req_valid), .req_wr_rdn(req_wr_rdn),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .config_regs(config_regs),
        .status_regs(status_regs), .cfg_wr_strobe(cfg_wr_strobe));

    always #5 clk = ~clk;

    typedef struct {int host; logic [RW-1:0] rd; logic err; logic [NC-1:0] stb;} exp_t;
    exp_t q[$];
    exp_t m_e;
    int checks = 0, failures = 0;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", n, act, exp);
        end
    endtask

    // Monitor: every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (|rsp_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp got=%b exp=none", rsp_valid);
            end else begin
                m_e = q.pop_front();
                chk("rsp_valid", 64'(rsp_valid), 64'(NH'(1) << m_e.host));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(m_e.rd));
                chk("rsp_err", 64'(rsp_err), 64'(m_e.err));
                chk("cfg_wr_strobe", 64'(cfg_wr_strobe), 64'(m_e.stb));
            end
        end
    end

    task automatic access(input int h, input logic wr, input logic [AW-1:0] a,
                          input logic [RW-1:0] wd, input logic [RW-1:0] rd,
                          input logic err, input logic [NC-1:0] stb);
        q.push_back('{h, rd, err, stb});
        req_valid[h] = 1'b1;
        req_wr_rdn[h] = wr;
        req_addr[h*AW +: AW] = a;
        req_wdata[h*RW +: RW] = wd;
        @(negedge clk);
        chk("req_ready", 64'(req_ready), 64'(NH'(1) << h));
        req_valid[h] = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int s = 0; s < NS; s++) status_regs[s*RW +: RW] = RW'(8'h10 + s);
        status_regs[RW +: RW] = 8'h5A;
        ena = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_cfg0", 64'(config_regs[RW-1:0]), 64'hA5);
        chk("rst_cfg_all", 64'(config_regs), 64'(CR));
        chk("rst_req_ready", 64'(req_ready), 0);
        chk("rst_rsp_valid", 64'(rsp_valid), 0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 0);
        chk("rst_rsp_err", 64'(rsp_err), 0);
        chk("rst_strobe", 64'(cfg_wr_strobe), 0);
        rstb = 1'b1;
        @(negedge clk);
        access(0, 1'b1, 8'd2, 8'h3C, 8'h00, 1'b0, 8'h04);
        chk("cfg2_written", 64'(config_regs[2*RW +: RW]), 64'h3C);
        access(0, 1'b0, 8'd2, 8'h00, 8'h3C, 1'b0, 8'h00);
        access(1, 1'b0, 8'd9, 8'h00, 8'h5A, 1'b0, 8'h00);
        access(0, 1'b1, 8'd9, 8'h11, 8'h00, 1'b1, 8'h00);
        access(1, 1'b0, 8'd16, 8'h00, 8'h00, 1'b1, 8'h00);
        access(1, 1'b1, 8'd16, 8'hEE, 8'h00, 1'b1, 8'h00);
        chk("cfg_unchanged", 64'(config_regs), 64'h0000_0000_003C_00A5);
        // ena low blocks grants; dropping it during EXEC must not abort the access
        ena = 1'b0;
        req_valid[0] = 1'b1;
        req_wr_rdn[0] = 1'b1;
        req_addr[0 +: AW] = 8'd3;
        req_wdata[0 +: RW] = 8'h77;
        repeat (5) begin
            @(negedge clk);
            chk("ena_block", 64'(req_ready), 0);
        end
        q.push_back('{0, 8'h00, 1'b0, 8'h08});
        ena = 1'b1;
        @(negedge clk);
        chk("ena_grant", 64'(req_ready), 64'h1);
        ena = 1'b0;
        req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("cfg3_written", 64'(config_regs), 64'h0000_0000_773C_00A5);
        ena = 1'b1;
        req_valid[0] = 1'b1;
        req_wr_rdn[0] = 1'b1;
        req_addr[0 +: AW] = 8'd0;
        req_wdata[0 +: RW] = 8'hFF;
        @(negedge clk);
        chk("rst_exec_grant", 64'(req_ready), 64'h1);
        rstb = 1'b0;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("rst_exec_no_rsp", 64'(rsp_valid), 0);
        chk("rst_exec_cfg", 64'(config_regs), 64'(CR));
        chk("rst_exec_strobe", 64'(cfg_wr_strobe), 0);
        rstb = 1'b1;
        @(negedge clk);
        // Both hosts request continuously: grants alternate starting at host 0
        for (int i = 0; i < 2; i++) begin
            q.push_back('{0, 8'h5A, 1'b0, 8'h00});
            q.push_back('{1, 8'hA5, 1'b0, 8'h00});
        end
        req_wr_rdn = '0;
        req_addr[0 +: AW] = 8'd9;
        req_addr[AW +: AW] = 8'd0;
        req_valid = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k % 2 == 1) chk("rr_grant", 64'(req_ready), (k % 4 == 1) ? 64'h1 : 64'h2);
            if (k == 7) req_valid = '0;
        end
        repeat (2) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multi_host_reg_bank.md
# multi_host_reg_bank

Parametrised successor to the single-host SPI wrapper register path. Arbitrates register accesses from NUM_HOSTS host interfaces (SPI, I2C, future debug port) onto one shared config/status register bank using a fair round-robin scheme and a registered request/response handshake. Adds address-range and write-protection error reporting and per-register write strobes. Sits between the host peripherals and the design's config/status vectors.

## Interface
Parameters:
- NUM_HOSTS, 2, number of host request channels (1..8)
- NUM_CFG, 8, number of read/write config registers
- NUM_STATUS, 8, number of read-only status registers
- REG_WIDTH, 8, register and data width
- ADDR_W, 8, host address width; NUM_CFG+NUM_STATUS ≤ 2**ADDR_W
- CFG_RESET, '0, NUM_CFG*REG_WIDTH reset image of config registers (reg k = bits [k*REG_WIDTH +: REG_WIDTH])

Ports:
- clk  in  1  clock; the only clock
- rstb  in  1  synchronous active-low reset
- ena  in  1  accept-enable; low blocks new grants
- req_valid  in  NUM_HOSTS  host i requests an access
- req_wr_rdn  in  NUM_HOSTS  1 = write, 0 = read
- req_addr  in  NUM_HOSTS*ADDR_W  host i address at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_HOSTS*REG_WIDTH  host i write data
- req_ready  out  NUM_HOSTS  one-cycle acceptance pulse, one-hot
- rsp_valid  out  NUM_HOSTS  one-cycle completion pulse, one-hot
- rsp_rdata  out  REG_WIDTH  read data, valid with rsp_valid
- rsp_err  out  1  error flag, valid with rsp_valid
- config_regs  out  NUM_CFG*REG_WIDTH  config register contents
- status_regs  in  NUM_STATUS*REG_WIDTH  status register inputs
- cfg_wr_strobe  out  NUM_CFG  one-cycle pulse when config reg k is written

## Operation
- Address map: 0..NUM_CFG-1 config (RW); NUM_CFG..NUM_CFG+NUM_STATUS-1 status (RO); anything above is unmapped.
- FSM states IDLE, EXEC. Reset → IDLE.
- IDLE: if ena=1 and any req_valid, select winner, latch its wr_rdn/addr/wdata and index, go EXEC. Otherwise stay.
- EXEC: perform access, go IDLE unconditionally. req_valid ignored in EXEC.
- Round-robin: pointer last_grant (reset NUM_HOSTS-1); search starts at last_grant+1 modulo NUM_HOSTS; winner becomes last_grant. A lone requester always wins.
- Access results:
  - write config k: reg k ← wdata, cfg_wr_strobe[k]=1, err=0, rdata=0.
  - read config k: rdata = reg k, err=0.
  - read status s: rdata = status_regs slot s sampled at the EXEC edge, err=0.
  - write status: no state change, no strobe, err=1, rdata=0.
  - unmapped read or write: no state change, err=1, rdata=0.
- ena low in EXEC does not abort the in-flight access.

## Timing
- All outputs registered. Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, cfg_wr_strobe=0, config_regs=CFG_RESET, last_grant=NUM_HOSTS-1.
- Edge E0 (end of IDLE cycle with grant): req_ready[i]=1 during the following (EXEC) cycle.
- Edge E1 (end of EXEC): register write takes effect; rsp_valid[i], rsp_rdata, rsp_err, cfg_wr_strobe asserted for exactly the next cycle; new config value visible in the same cycle as the strobe.
- Latency: request sampled at E0 → response 2 cycles after the sampling cycle begins; max throughput one access per 2 cycles.
- Host rule: on seeing req_ready, host drops req_valid or presents its next request by the following cycle; a valid still high in the IDLE cycle is a new request.
- The IDLE cycle coinciding with rsp_valid may grant a new request.
- Reset asserted mid-EXEC: access discarded, no rsp_valid, no write, all outputs to reset values on the next edge.

## Test plan
- Reset: CFG_RESET=0x..A5 in reg 0; after rstb low one cycle, config reg 0 = 0xA5, all handshake outputs 0.
- Single write/read: host 0 writes 0x3C to addr 2 → req_ready[0] one cycle later, then rsp_valid[0], rsp_err=0, cfg_wr_strobe[2]=1, reg 2 = 0x3C; read addr 2 returns 0x3C.
- Status read and protection: status slot 1 = 0x5A, read addr NUM_CFG+1 → rdata 0x5A; write addr NUM_CFG+1 → rsp_err=1, no strobe, status unaffected.
- Unmapped: read addr NUM_CFG+NUM_STATUS → rsp_err=1, rdata=0; write there → rsp_err=1, config_regs unchanged.
- Round-robin: both hosts hold valid continuously for 4 accesses → grants alternate 0,1,0,1; each rsp_valid one-hot to its host.
- ena/reset: ena=0 with valid high → no req_ready for 5 cycles; ena dropped during EXEC → access still completes; rstb low during EXEC of write 0xFF → no rsp_valid, reg keeps CFG_RESET value.
